// File: rtl/oled_hex_writer.sv
// oled_hex_writer: queues {row, value, blank} requests and streams each value as 8 hex chars into the OLED buffer.
module oled_hex_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int COL_BASE   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [1:0]  reqRow,
  input  logic [31:0] reqData,
  input  logic        reqBlank,
  output logic        writeOLED,
  output logic [8:0]  index,
  output logic [7:0]  writeData,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t r_state, w_state_nx;
  logic [34:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic [34:0]   r_cur, w_src;
  logic [2:0]    r_digit, w_i;
  logic          r_lead, w_lead_in, w_blank;
  logic          w_push, w_load, w_adv;
  logic [3:0]    w_nib, w_col;
  logic [7:0]    w_code;
  assign reqReady = r_count < (AW+1)'(FIFO_DEPTH);
  assign w_push   = reqValid && reqReady;
  assign busy     = (r_state == EMIT) || (r_count != '0);
  // Entry layout: {row[34:33], data[32:1], blank[0]}; a load emits character 0 of the head entry directly.
  always_comb begin
    w_load     = (r_state == IDLE || r_digit == 3'd7) && r_count != '0;
    w_adv      = !w_load && r_state == EMIT && r_digit != 3'd7;
    w_state_nx = (w_load || w_adv) ? EMIT : IDLE;
    w_src      = w_load ? r_mem[r_rd] : r_cur;
    w_i        = w_load ? 3'd0 : r_digit + 3'd1;
    w_lead_in  = w_load ? w_src[0] : r_lead;
    w_nib      = 4'(w_src[32:1] >> (5'd28 - {w_i, 2'b00}));
    w_blank    = w_lead_in && w_nib == 4'd0 && w_i != 3'd7;
    w_code     = w_blank ? 8'h20 : (w_nib <= 4'd9) ? 8'h30 + {4'h0, w_nib} : 8'h37 + {4'h0, w_nib};
    w_col      = 4'(COL_BASE) + {1'b0, w_i};
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= {reqRow, reqData, reqBlank};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_wr      <= '0;
      r_rd      <= '0;
      r_count   <= '0;
      r_cur     <= '0;
      r_digit   <= '0;
      r_lead    <= 1'b0;
      writeOLED <= 1'b0;
      index     <= '0;
      writeData <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_count   <= r_count + (AW+1)'(w_push) - (AW+1)'(w_load);
      writeOLED <= w_load || w_adv;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_load) begin
        r_rd  <= r_rd + 1'b1;
        r_cur <= w_src;
      end
      if (w_load || w_adv) begin
        r_digit   <= w_i;
        r_lead    <= w_blank;
        index     <= {w_src[34:33], w_col, 3'b000};
        writeData <= w_code;
      end
    end
  end
endmodule
